// File: rtl/buf_loader_if.sv
// Handshake and row-buffer write bus for buf_loader; master = upstream/bench side, slave = buf_loader.
interface buf_loader_if #(
  parameter int x_w   = 9,
  parameter int depth = 8,
  parameter int rows  = 4
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [x_w-1:0]  data_i;
  logic            v_i;
  logic            ready_o;
  logic [rows-1:0] w_vo;
  logic [AW-1:0]   addr_w_o;
  logic [x_w-1:0]  data_w_o;
  logic [rows-1:0] start_vo;
  logic            busy_o;

  modport master (
    output data_i, v_i,
    input  ready_o, w_vo, addr_w_o, data_w_o, start_vo, busy_o
  );

  modport slave (
    input  data_i, v_i,
    output ready_o, w_vo, addr_w_o, data_w_o, start_vo, busy_o
  );
endinterface

// File: rtl/buf_loader.sv
// Streams beats column-fastest into rows x depth buffers (write one cycle after accept), then issues readout starts and waits depth cycles; ready_o low outside LOAD, upstream holds.
// Optional BUF_LOADER_STAGGER_EN: one start bit per ISSUE cycle (rows cycles) instead of a single all-ones pulse.
module buf_loader #(
  parameter int x_w   = 9,
  parameter int depth = 8,
  parameter int rows  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  buf_loader_if.slave bus
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int RW = (rows > 1) ? $clog2(rows) : 1;
  localparam logic [AW-1:0]   COL_LAST = AW'(depth - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(rows - 1);
  localparam logic [rows-1:0] ROW0_BIT = rows'(1);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]      state;
  logic [AW-1:0]   col;
  logic [RW-1:0]   row;
  logic [rows-1:0] w_q;
  logic [AW-1:0]   addr_q;
  logic [x_w-1:0]  data_q;
  logic            accept;

  assign bus.ready_o  = (state == LOAD);
  assign bus.busy_o   = (state != LOAD);
  assign bus.w_vo     = w_q;
  assign bus.addr_w_o = addr_q;
  assign bus.data_w_o = data_q;
  assign accept       = bus.v_i && (state == LOAD);

`ifdef BUF_LOADER_STAGGER_EN
  assign bus.start_vo = (state == ISSUE) ? (ROW0_BIT << row) : '0;
`else
  assign bus.start_vo = (state == ISSUE) ? '1 : '0;
`endif

  // col doubles as the DRAIN cycle counter, row as the staggered ISSUE index;
  // both are zero on entry to those states and left at zero on exit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= LOAD;
      col    <= '0;
      row    <= '0;
      w_q    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      w_q <= '0;
      case (state)
        LOAD: begin
          if (accept) begin
            w_q    <= ROW0_BIT << row;
            addr_q <= col;
            data_q <= bus.data_i;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= FLUSH;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: state <= ISSUE;
        ISSUE: begin
`ifdef BUF_LOADER_STAGGER_EN
          if (row == ROW_LAST) begin
            row   <= '0;
            state <= DRAIN;
          end else begin
            row <= row + 1'b1;
          end
`else
          state <= DRAIN;
`endif
        end
        default: begin
          if (col == COL_LAST) begin
            col   <= '0;
            state <= LOAD;
          end else begin
            col <= col + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_buf_loader.sv
// Randomized scoreboard bench for buf_loader: frame-level reference model feeds per-cycle and per-write queues checked by a negedge monitor.
module tb_buf_loader;
  localparam int XW    = 9;
  localparam int DEPTH = 8;
  localparam int ROWS  = 4;
  localparam int NB    = ROWS * DEPTH;
`ifdef BUF_LOADER_STAGGER_EN
  localparam int IL = ROWS;
  localparam bit STAG = 1'b1;
`else
  localparam int IL = 1;
  localparam bit STAG = 1'b0;
`endif

  typedef struct {
    bit ready;
    int start;
    bit has_wr;
  } cyc_t;

  typedef struct {
    int row;
    int addr;
    int data;
  } wr_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  buf_loader_if #(.x_w(XW), .depth(DEPTH), .rows(ROWS)) bus ();

  buf_loader #(.x_w(XW), .depth(DEPTH), .rows(ROWS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  cyc_t exp_c[$];
  wr_t  exp_w[$];

  // reference model: beats accepted in the current frame, cycles since the frame completed
  int m_k    = 0;
  int m_post = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic fail_missing(input string nm);
    n_checks++;
    $display("FAIL %s: got empty queue expected an entry", nm);
  endtask

  // Drive one cycle's inputs, advance the model over the edge, push expectations for the next cycle.
  task automatic cycle(input bit v, input int d);
    cyc_t c;
    bus.v_i    = v;
    bus.data_i = XW'(d);
    @(posedge clk_i);
    c.has_wr = 1'b0;
    if (m_post == 0) begin
      if (v) begin
        exp_w.push_back('{row: m_k / DEPTH, addr: m_k % DEPTH, data: d});
        c.has_wr = 1'b1;
        m_k++;
        if (m_k == NB) begin
          m_k    = 0;
          m_post = 1;
        end
      end
    end else if (m_post == 1 + IL + DEPTH) begin
      m_post = 0;
    end else begin
      m_post++;
    end
    c.ready = (m_post == 0);
    if (m_post >= 2 && m_post <= 1 + IL) c.start = STAG ? (1 << (m_post - 2)) : ((1 << ROWS) - 1);
    else c.start = 0;
    exp_c.push_back(c);
    mon_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    #2;
    mon_en = 1'b0;
    rst_i  = 1'b0;
    #1;
    check("rst_w_vo", int'(bus.w_vo), 0);
    check("rst_start_vo", int'(bus.start_vo), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_addr", int'(bus.addr_w_o), 0);
    check("rst_data", int'(bus.data_w_o), 0);
    exp_c.delete();
    exp_w.delete();
    m_k    = 0;
    m_post = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  always @(negedge clk_i) begin
    cyc_t c;
    wr_t  w;
    if (mon_en) begin
      if (exp_c.size() == 0) fail_missing("cyc_record");
      else begin
        c = exp_c.pop_front();
        check("ready_o", int'(bus.ready_o), int'(c.ready));
        check("busy_o", int'(bus.busy_o), int'(!c.ready));
        check("start_vo", int'(bus.start_vo), c.start);
        check("wr_present", int'(bus.w_vo != '0), int'(c.has_wr));
      end
      if (bus.w_vo != '0) begin
        if (exp_w.size() == 0) fail_missing("wr_record");
        else begin
          w = exp_w.pop_front();
          check("w_vo", int'(bus.w_vo), 1 << w.row);
          check("addr_w_o", int'(bus.addr_w_o), w.addr);
          check("data_w_o", int'(bus.data_w_o), w.data);
        end
      end
    end
  end

  initial begin
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    #3;
    check("init_w_vo", int'(bus.w_vo), 0);
    check("init_start_vo", int'(bus.start_vo), 0);
    check("init_busy", int'(bus.busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // back-to-back frame with data 0..31, then idle through flush/issue/drain
    for (int k = 0; k < NB; k++) cycle(1'b1, k);
    for (int k = 0; k < 2 + IL + DEPTH + 3; k++) cycle(1'b0, 0);

    // alternate-cycle valid with v_i also asserted while busy
    for (int k = 0; k < 2 * NB + IL + DEPTH + 6; k++) cycle(k[0] == 1'b0, int'($urandom_range(0, 511)));

    // random valid density across several frames
    for (int k = 0; k < 400; k++) cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)));

    // reset after 13 beats of a fresh frame, then a single beat of 99
    for (int k = 0; k < 30; k++) cycle(1'b0, 0);
    for (int k = 0; k < 13; k++) cycle(1'b1, int'($urandom_range(0, 511)));
    do_reset();
    cycle(1'b1, 99);
    for (int k = 0; k < 4; k++) cycle(1'b0, 0);

    // reset in the middle of a drain
    for (int k = 0; k < NB - 1; k++) cycle(1'b1, int'($urandom_range(0, 511)));
    for (int k = 0; k < 2 + IL + 3; k++) cycle(1'b0, 0);
    do_reset();
    for (int k = 0; k < NB + 5; k++) cycle(1'b1, int'($urandom_range(0, 511)));
    for (int k = 0; k < 2 + IL + DEPTH + 3; k++) cycle(1'b0, 0);

    @(negedge clk_i);
    #1;
    mon_en = 1'b0;
    check("wr_leftover", exp_w.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
